// File: rtl/ext_pipe.sv
// ext_pipe: pipelined immediate / load-data extender with valid/ready handshake, tag and flush.
// Define EXT_ERR_EN to build a registered misaligned-halfword flag on out_err_o.
module ext_pipe #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IMM_W  = 16,
    parameter int unsigned STAGES = 2,
    parameter int unsigned TAG_W  = 5,
    localparam int unsigned AddrW = $clog2(DATA_W / 8)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [2:0]        in_op_i,
    input  logic [AddrW-1:0]  in_addr_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [TAG_W-1:0]  in_tag_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [TAG_W-1:0]  out_tag_o,
    output logic              out_err_o
);
    localparam logic [2:0] OpZext = 3'b000;
    localparam logic [2:0] OpSext = 3'b001;
    localparam logic [2:0] OpLui  = 3'b010;
    localparam logic [2:0] OpLb   = 3'b011;
    localparam logic [2:0] OpLbu  = 3'b100;
    localparam logic [2:0] OpLh   = 3'b101;
    localparam logic [2:0] OpLhu  = 3'b110;

    logic [IMM_W-1:0]  imm;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [AddrW+2:0]  byte_pos;
    logic [AddrW+2:0]  half_pos;
    logic [DATA_W-1:0] ext_d;

    logic [STAGES-1:0] valid_q;
    logic [DATA_W-1:0] data_q [STAGES];
    logic [TAG_W-1:0]  tag_q  [STAGES];
    logic [STAGES-1:0] load;
    logic [STAGES-1:0] src_valid;
    logic [DATA_W-1:0] src_data [STAGES];
    logic [TAG_W-1:0]  src_tag  [STAGES];

    always_comb begin
        imm      = in_data_i[IMM_W-1:0];
        byte_pos = {in_addr_i, 3'b000};
        // Halfwords are always taken from the aligned pair, even if in_addr_i[0] is set.
        half_pos = {in_addr_i[AddrW-1:1], 4'b0000};
        byte_sel = in_data_i[byte_pos +: 8];
        half_sel = in_data_i[half_pos +: 16];
        case (in_op_i)
            OpZext:  ext_d = {{(DATA_W - IMM_W){1'b0}}, imm};
            OpSext:  ext_d = {{(DATA_W - IMM_W){imm[IMM_W-1]}}, imm};
            OpLui:   ext_d = {imm, {(DATA_W - IMM_W){1'b0}}};
            OpLb:    ext_d = {{(DATA_W - 8){byte_sel[7]}}, byte_sel};
            OpLbu:   ext_d = {{(DATA_W - 8){1'b0}}, byte_sel};
            OpLh:    ext_d = {{(DATA_W - 16){half_sel[15]}}, half_sel};
            OpLhu:   ext_d = {{(DATA_W - 16){1'b0}}, half_sel};
            default: ext_d = in_data_i;
        endcase
    end

    // A stage can load when empty or when everything downstream of it is moving.
    always_comb begin
        load = '0;
        load[STAGES-1] = ~valid_q[STAGES-1] | out_ready_i;
        for (int i = STAGES - 2; i >= 0; i--) begin
            load[i] = ~valid_q[i] | load[i+1];
        end
    end

    always_comb begin
        src_valid[0] = in_valid_i;
        src_data[0]  = ext_d;
        src_tag[0]   = in_tag_i;
        for (int i = 1; i < STAGES; i++) begin
            src_valid[i] = valid_q[i-1];
            src_data[i]  = data_q[i-1];
            src_tag[i]   = tag_q[i-1];
        end
    end

    assign in_ready_o  = load[0] & ~flush_i & ~reset_i;
    assign out_valid_o = valid_q[STAGES-1];
    assign out_data_o  = data_q[STAGES-1];
    assign out_tag_o   = tag_q[STAGES-1];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            valid_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else if (flush_i) begin
            valid_q <= '0;
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (load[i]) begin
                    valid_q[i] <= src_valid[i];
                    if (src_valid[i]) begin
                        data_q[i] <= src_data[i];
                        tag_q[i]  <= src_tag[i];
                    end
                end
            end
        end
    end

`ifdef EXT_ERR_EN
    logic              err_d;
    logic [STAGES-1:0] err_q;
    logic [STAGES-1:0] src_err;

    assign err_d = ((in_op_i == OpLh) || (in_op_i == OpLhu)) && in_addr_i[0];

    always_comb begin
        src_err[0] = err_d;
        for (int i = 1; i < STAGES; i++) begin
            src_err[i] = err_q[i-1];
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            err_q <= '0;
        end else if (!flush_i) begin
            for (int i = 0; i < STAGES; i++) begin
                if (load[i] && src_valid[i]) begin
                    err_q[i] <= src_err[i];
                end
            end
        end
    end

    assign out_err_o = err_q[STAGES-1];
`else
    assign out_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_ext_pipe.sv
// Directed self-checking bench for ext_pipe (DATA_W=32, STAGES=2, TAG_W=5).
module tb_ext_pipe;
    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [1:0]  in_addr;
    logic [31:0] in_data;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_tag;
    logic        out_err;

    int total = 0;
    int bad   = 0;
    int sent;
    logic [4:0] got[$];

`ifdef EXT_ERR_EN
    localparam logic ErrOn = 1'b1;
`else
    localparam logic ErrOn = 1'b0;
`endif

    ext_pipe dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_op_i     (in_op),
        .in_addr_i   (in_addr),
        .in_data_i   (in_data),
        .in_tag_i    (in_tag),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_tag_o   (out_tag),
        .out_err_o   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    task automatic check(input string nm, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", nm, obs, exp);
        end
    endtask

    // Entry: #1 after a posedge with an empty pipeline and out_ready=1.
    task automatic xfer(input string nm, input logic [2:0] op, input logic [1:0] addr,
                        input logic [31:0] data, input logic [4:0] tag,
                        input logic [31:0] exp, input logic exp_err);
        check({nm, ":rdy"}, {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1;
        in_op    = op;
        in_addr  = addr;
        in_data  = data;
        in_tag   = tag;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({nm, ":lat"}, {63'd0, out_valid}, 64'd0);
        @(posedge clk); #1;
        check({nm, ":vld"}, {63'd0, out_valid}, 64'd1);
        check({nm, ":data"}, {32'd0, out_data}, {32'd0, exp});
        check({nm, ":tag"}, {59'd0, out_tag}, {59'd0, tag});
        check({nm, ":err"}, {63'd0, out_err}, {63'd0, exp_err});
    endtask

    task automatic present(input logic [4:0] tag);
        in_valid = 1'b1;
        in_op    = 3'b111;
        in_addr  = 2'd0;
        in_data  = 32'h1111_1111 * tag;
        in_tag   = tag;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = '0; in_addr = '0;
        in_data = '0; in_tag = '0; out_ready = 1'b1;
        #1;
        check("rst:valid", {63'd0, out_valid}, 64'd0);
        check("rst:data", {32'd0, out_data}, 64'd0);
        check("rst:tag", {59'd0, out_tag}, 64'd0);
        check("rst:err", {63'd0, out_err}, 64'd0);
        check("rst:rdy", {63'd0, in_ready}, 64'd0);
        @(posedge clk); @(posedge clk); @(negedge clk);
        reset = 1'b0;
        #1 check("rel:rdy", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;

        xfer("sext", 3'b001, 2'd0, 32'h0000_8000, 5'd1, 32'hFFFF_8000, 1'b0);
        xfer("zext", 3'b000, 2'd0, 32'h0000_8000, 5'd2, 32'h0000_8000, 1'b0);
        xfer("lui",  3'b010, 2'd0, 32'h0000_1234, 5'd3, 32'h1234_0000, 1'b0);
        xfer("lb1",  3'b011, 2'd1, 32'h12F4_80A5, 5'd4, 32'hFFFF_FF80, 1'b0);
        xfer("lbu3", 3'b100, 2'd3, 32'h12F4_80A5, 5'd5, 32'h0000_0012, 1'b0);
        xfer("lh0",  3'b101, 2'd0, 32'h12F4_80A5, 5'd6, 32'hFFFF_80A5, 1'b0);
        xfer("lhu2", 3'b110, 2'd2, 32'h12F4_80A5, 5'd7, 32'h0000_12F4, 1'b0);
        xfer("word", 3'b111, 2'd2, 32'h12F4_80A5, 5'd8, 32'h12F4_80A5, 1'b0);
        xfer("lh1",  3'b101, 2'd1, 32'h12F4_80A5, 5'd9, 32'hFFFF_80A5, ErrOn);
        xfer("lhu3", 3'b110, 2'd3, 32'h12F4_80A5, 5'd10, 32'h0000_12F4, ErrOn);
        xfer("lb1e", 3'b011, 2'd1, 32'h12F4_80A5, 5'd11, 32'hFFFF_FF80, 1'b0);
        @(posedge clk); #1;

        // Backpressure: two acceptances fill the pipe, then it must stall and hold.
        out_ready = 1'b0;
        present(5'd1);
        check("bp:rdy1", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        present(5'd2);
        check("bp:rdy2", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        present(5'd3);
        for (int k = 0; k < 3; k++) begin
            check("bp:full", {63'd0, in_ready}, 64'd0);
            check("bp:vld", {63'd0, out_valid}, 64'd1);
            check("bp:tag", {59'd0, out_tag}, 64'd1);
            check("bp:data", {32'd0, out_data}, 64'h1111_1111);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1 check("bp:rel_rdy", {63'd0, in_ready}, 64'd1);
        sent = 2;
        for (int c = 0; c < 20 && got.size() < 4; c++) begin
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                got.push_back(out_tag);
                check("bp:rx_data", {32'd0, out_data}, {32'd0, 32'h1111_1111 * out_tag});
            end
            @(posedge clk); #1;
            if (sent < 4) present(5'(sent + 1));
            else in_valid = 1'b0;
        end
        check("bp:count", 64'(got.size()), 64'd4);
        for (int k = 0; k < got.size(); k++) begin
            check("bp:order", {59'd0, got[k]}, 64'(k + 1));
        end

        // Flush with two items in flight.
        out_ready = 1'b0;
        present(5'd5);
        @(posedge clk); #1;
        present(5'd6);
        @(posedge clk); #1;
        present(5'd7);
        flush = 1'b1;
        #1 check("fl:rdy", {63'd0, in_ready}, 64'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl:vld", {63'd0, out_valid}, 64'd0);
        check("fl:keep_tag", {59'd0, out_tag}, 64'd5);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("fl:gone", {63'd0, out_valid}, 64'd0);
        end
        check("fl:rdy_after", {63'd0, in_ready}, 64'd1);

        // Asynchronous reset with the pipe full, between edges.
        @(posedge clk); #1;
        out_ready = 1'b0;
        present(5'd8);
        @(posedge clk); #1;
        present(5'd9);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("ar:pre_vld", {63'd0, out_valid}, 64'd1);
        #3 reset = 1'b1;
        #1;
        check("ar:vld", {63'd0, out_valid}, 64'd0);
        check("ar:data", {32'd0, out_data}, 64'd0);
        check("ar:tag", {59'd0, out_tag}, 64'd0);
        check("ar:rdy", {63'd0, in_ready}, 64'd0);
        #2 reset = 1'b0;
        #1;
        check("ar:rel_rdy", {63'd0, in_ready}, 64'd1);
        check("ar:rel_vld", {63'd0, out_valid}, 64'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        xfer("post", 3'b001, 2'd0, 32'h0000_7FFF, 5'd12, 32'h0000_7FFF, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
